fetch_stage: RTL and testbench

- Front-end fetch unit directly upstream of the instruction buffer.
- Holds the fetch PC and requests one aligned line of FETCH_WIDTH instructions from the icache per request.
- Buffers the returned line and pushes up to FETCH_WIDTH FETCH_PACKETs per cycle into the instruction buffer, throttled by the buffer's available_slots.
- Redirects on branch mispredict and discards any stale in-flight icache response.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage : PC holder, icache line requester and instruction pusher    |
// |               feeding the instruction buffer, with mispredict redirect.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+

package fetch_stage_pkg;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } fetch_packet_t;
endpackage

module fetch_stage #(
    parameter int          FETCH_WIDTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              redirect_valid,
    input  logic [31:0]                                       redirect_pc,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]                  ib_available_slots,
    output logic [$clog2(FETCH_WIDTH+1)-1:0]                  num_pushes,
    output fetch_stage_pkg::fetch_packet_t [FETCH_WIDTH-1:0]  new_ib_entry,
    output logic                                              icache_req_valid,
    output logic [31:0]                                       icache_req_addr,
    input  logic                                              icache_req_ready,
    input  logic                                              icache_resp_valid,
    input  logic [32*FETCH_WIDTH-1:0]                         icache_resp_data,
    output logic [31:0]                                       fetch_pc_dbg,
    output logic [1:0]                                        state_dbg
);

    localparam int LINE_BYTES = 4 * FETCH_WIDTH;
    localparam int OB         = $clog2(LINE_BYTES);
    localparam int OW         = OB - 2;
    localparam int CW         = $clog2(FETCH_WIDTH + 1);

    localparam logic [1:0] S_REQ     = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DELIVER = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    logic [31:0]                  pc_q, pc_d;
    logic [1:0]                   state_q, state_d;
    logic [CW-1:0]                rem_q, rem_d;
    logic [FETCH_WIDTH-1:0][31:0] line_q, line_d;

    logic [CW-1:0] push_cnt;
    logic [31:0]   base_addr;
    logic [OW-1:0] offset;
    logic          unused_pc_bits;

    assign base_addr      = {pc_q[31:OB], {OB{1'b0}}};
    assign offset         = pc_q[OB-1:2];
    assign unused_pc_bits = ^redirect_pc[1:0];

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        rem_d            = rem_q;
        line_d           = line_q;
        push_cnt         = '0;
        icache_req_valid = 1'b0;

        case (state_q)
            S_REQ: begin
                icache_req_valid = 1'b1;
                if (icache_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (icache_resp_valid) begin
                    line_d  = icache_resp_data;
                    rem_d   = CW'(FETCH_WIDTH) - CW'(offset);
                    state_d = S_DELIVER;
                end
            end
            S_DELIVER: begin
                push_cnt = (ib_available_slots < rem_q) ? ib_available_slots : rem_q;
                pc_d     = pc_q + (32'(push_cnt) << 2);
                rem_d    = rem_q - push_cnt;
                if (push_cnt == rem_q) state_d = S_REQ;
            end
            default: begin
                if (icache_resp_valid) state_d = S_REQ;
            end
        endcase

        // A response arriving alongside the redirect is consumed and dropped,
        // so DISCARD only persists while that response is still outstanding.
        if (redirect_valid) begin
            push_cnt = '0;
            pc_d     = {redirect_pc[31:2], 2'b00};
            rem_d    = '0;
            line_d   = line_q;
            case (state_q)
                S_REQ:     state_d = icache_req_ready  ? S_DISCARD : S_REQ;
                S_WAIT:    state_d = icache_resp_valid ? S_REQ     : S_DISCARD;
                S_DELIVER: state_d = S_REQ;
                default:   state_d = icache_resp_valid ? S_REQ     : S_DISCARD;
            endcase
        end

        if (reset) begin
            icache_req_valid = 1'b0;
            push_cnt         = '0;
        end
    end

    always_comb begin
        new_ib_entry = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (CW'(i) < push_cnt) begin
                new_ib_entry[i].inst = line_q[offset + OW'(i)];
                new_ib_entry[i].pc   = pc_q + (32'(i) << 2);
                new_ib_entry[i].npc  = pc_q + (32'(i) << 2) + 32'd4;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= S_REQ;
            rem_q   <= '0;
            line_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            line_q  <= line_d;
        end
    end

    assign num_pushes      = push_cnt;
    assign icache_req_addr = base_addr;
    assign fetch_pc_dbg    = pc_q;
    assign state_dbg       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_stage : randomized bench for fetch_stage against a queue model  |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+

module tb_fetch_stage;

    localparam int          FW       = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic                                     clock = 1'b0;
    logic                                     reset;
    logic                                     redirect_valid;
    logic [31:0]                              redirect_pc;
    logic [2:0]                               ib_available_slots;
    logic [2:0]                               num_pushes;
    fetch_stage_pkg::fetch_packet_t [FW-1:0]  new_ib_entry;
    logic                                     icache_req_valid;
    logic [31:0]                              icache_req_addr;
    logic                                     icache_req_ready;
    logic                                     icache_resp_valid;
    logic [32*FW-1:0]                         icache_resp_data;
    logic [31:0]                              fetch_pc_dbg;
    logic [1:0]                               state_dbg;

    fetch_stage #(.FETCH_WIDTH(FW), .RESET_PC(RESET_PC)) dut (
        .clock              (clock),
        .reset              (reset),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .ib_available_slots (ib_available_slots),
        .num_pushes         (num_pushes),
        .new_ib_entry       (new_ib_entry),
        .icache_req_valid   (icache_req_valid),
        .icache_req_addr    (icache_req_addr),
        .icache_req_ready   (icache_req_ready),
        .icache_resp_valid  (icache_resp_valid),
        .icache_resp_data   (icache_resp_data),
        .fetch_pc_dbg       (fetch_pc_dbg),
        .state_dbg          (state_dbg)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    // Model: pending instructions still to be delivered, plus icache bookkeeping.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_stale;

    bit          ic_pend;
    int          ic_dly;
    logic [31:0] ic_addr;

    initial begin
        int          exp_push;
        bit          exp_req;
        logic [1:0]  exp_state;
        logic [31:0] base;
        bit          accepted;
        int          off;

        reset              = 1'b1;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        ib_available_slots = '0;
        icache_req_ready   = 1'b0;
        icache_resp_valid  = 1'b0;
        icache_resp_data   = '0;
        m_pc = RESET_PC; m_out = 0; m_stale = 0;
        ic_pend = 0; ic_dly = 0; ic_addr = '0;

        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clock);
            reset          = (cyc < 2) || ($urandom_range(0, 249) == 0);
            redirect_valid = !reset && ($urandom_range(0, 13) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
                default: redirect_pc = 32'($urandom_range(0, 255));
            endcase
            ib_available_slots = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 4));
            icache_req_ready   = ($urandom_range(0, 3) != 0);
            icache_resp_valid  = !reset && ic_pend && (ic_dly == 0);
            for (int k = 0; k < FW; k++)
                icache_resp_data[32*k +: 32] = icache_resp_valid ? word_at(ic_addr + 32'(4*k)) : $urandom;
            #1;

            base     = {m_pc[31:4], 4'b0000};
            exp_req  = !reset && !m_out && (q.size() == 0);
            exp_push = (reset || redirect_valid || q.size() == 0) ? 0
                     : ((q.size() < int'(ib_available_slots)) ? q.size() : int'(ib_available_slots));
            if (q.size() != 0)       exp_state = 2'd2;
            else if (m_out && m_stale) exp_state = 2'd3;
            else if (m_out)          exp_state = 2'd1;
            else                     exp_state = 2'd0;

            check("req_valid", 32'(icache_req_valid), 32'(exp_req));
            check("num_pushes", 32'(num_pushes), 32'(exp_push));
            if (exp_req) check("req_addr", icache_req_addr, base);
            if (!reset) begin
                check("pc_dbg", fetch_pc_dbg, m_pc);
                check("state_dbg", 32'(state_dbg), 32'(exp_state));
            end
            for (int i = 0; i < FW; i++) begin
                if (i < exp_push) begin
                    check($sformatf("e%0d.inst", i), new_ib_entry[i].inst, q[i].inst);
                    check($sformatf("e%0d.pc", i),   new_ib_entry[i].pc,   q[i].pc);
                    check($sformatf("e%0d.npc", i),  new_ib_entry[i].npc,  q[i].pc + 32'd4);
                end else begin
                    check($sformatf("e%0d.zero_inst", i), new_ib_entry[i].inst, 32'h0);
                    check($sformatf("e%0d.zero_pc", i),   new_ib_entry[i].pc,   32'h0);
                    check($sformatf("e%0d.zero_npc", i),  new_ib_entry[i].npc,  32'h0);
                end
            end

            @(posedge clock);
            accepted = exp_req && icache_req_ready;
            if (reset) begin
                q.delete();
                m_pc = RESET_PC; m_out = 0; m_stale = 0;
                ic_pend = 0; ic_dly = 0;
            end else begin
                if (icache_resp_valid)          ic_pend = 0;
                else if (ic_pend && ic_dly > 0) ic_dly--;
                if (accepted) begin
                    ic_pend = 1; ic_addr = base; ic_dly = $urandom_range(0, 2);
                end

                if (redirect_valid) begin
                    q.delete();
                    m_pc = {redirect_pc[31:2], 2'b00};
                    if (accepted) begin
                        m_out = 1; m_stale = 1;
                    end else if (m_out) begin
                        if (icache_resp_valid) begin m_out = 0; m_stale = 0; end
                        else m_stale = 1;
                    end
                end else if (q.size() != 0) begin
                    for (int j = 0; j < exp_push; j++) void'(q.pop_front());
                    m_pc = m_pc + 32'(4 * exp_push);
                end else if (accepted) begin
                    m_out = 1; m_stale = 0;
                end else if (m_out && icache_resp_valid) begin
                    if (!m_stale) begin
                        off = int'(m_pc[3:2]);
                        for (int k = off; k < FW; k++)
                            q.push_back('{inst: icache_resp_data[32*k +: 32], pc: base + 32'(4*k)});
                    end
                    m_out = 0; m_stale = 0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
